// File: rtl/fc_pkg.sv
// Shared definitions for the FC stream transmitter: state encoding, default sizes, clog2 helper.
package fc_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } fc_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_piso.sv
// N x DATA_W parallel-load / serial-shift register; dout is always sample 0 of the register.
module fc_piso
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N      = DEF_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [N*DATA_W-1:0]   din,
    output logic [DATA_W-1:0]     dout
);

    logic [N*DATA_W-1:0] sr;

    // Shifting moves sample k+1 into slot k; zeros fill from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {DATA_W'(0), sr[N*DATA_W-1:DATA_W]};
        end
    end

    assign dout = sr[DATA_W-1:0];

endmodule

// File: rtl/fc_stream_tx.sv
// Serialises one feature vector per handshake into the FC engine and captures its returned result.
module fc_stream_tx
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned N           = DEF_N,
    parameter int unsigned GAP         = 1,
    parameter int unsigned WAIT_RESULT = 1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [N*DATA_W-1:0] vec_data,
    output logic                tx_valid,
    output logic [DATA_W-1:0]   tx_data,
    input  logic                res_valid,
    input  logic [DATA_W-1:0]   res_data,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                err_tmo
);

    localparam int unsigned IW = clog2(N);
    localparam int unsigned GW = clog2(GAP + 1);
    localparam int unsigned WW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    fc_state_e         state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic [WW-1:0]     wait_cnt, wait_nxt;
    logic              got_res, got_nxt;
    logic              vec_ready_nxt, tx_valid_nxt, out_valid_nxt, err_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              load, shift, capture;

    fc_piso #(.DATA_W(DATA_W), .N(N)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (vec_data),
        .dout  (tx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            got_res   <= 1'b0;
            vec_ready <= 1'b1;
            tx_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_tmo   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_nxt;
            wait_cnt  <= wait_nxt;
            got_res   <= got_nxt;
            vec_ready <= vec_ready_nxt;
            tx_valid  <= tx_valid_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            err_tmo   <= err_nxt;
        end
    end

    // Only the first result after a burst is taken, and only while the engine may legally answer.
    assign capture = res_valid && !got_res && (state == ST_GAP || state == ST_WAIT);

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        gap_nxt       = gap_cnt;
        wait_nxt      = wait_cnt;
        got_nxt       = got_res;
        out_valid_nxt = 1'b0;
        out_data_nxt  = out_data;
        err_nxt       = err_tmo;
        load          = 1'b0;
        shift         = 1'b0;

        if (capture) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = res_data;
            got_nxt       = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (vec_valid && vec_ready) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    got_nxt   = 1'b0;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (idx == IW'(N - 1)) begin
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end else begin
                    idx_nxt = idx + IW'(1);
                    shift   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    if (WAIT_RESULT != 0 && !got_res && !res_valid) begin
                        wait_nxt  = '0;
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    state_nxt = ST_IDLE;
                end else if (TIMEOUT > 0 && wait_cnt == WW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (TIMEOUT > 0) begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        vec_ready_nxt = (state_nxt == ST_IDLE);
        tx_valid_nxt  = (state_nxt == ST_SEND);
    end

endmodule

// File: tb/tb_fc_stream_tx.sv
// Bench for fc_stream_tx with a behavioural FC dot-product engine (weights 16..128, FRAC=4).
module tb_fc_stream_tx;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vec_valid;
    logic        vec_ready;
    logic [63:0] vec_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        err_tmo;

    logic        eng_en;
    logic        spur;
    logic [7:0]  spur_data;
    int          eng_cnt;
    int          eng_acc;
    logic        eng_rv;
    logic [7:0]  eng_rd;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ov_count = 0;
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    fc_stream_tx #(.DATA_W(8), .N(8), .GAP(1), .WAIT_RESULT(1), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .err_tmo   (err_tmo)
    );

    // Engine: accumulates w[k]*x[k], answers one cycle after the first idle cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_cnt <= 0;
            eng_acc <= 0;
            eng_rv  <= 1'b0;
            eng_rd  <= '0;
        end else begin
            eng_rv <= 1'b0;
            if (tx_valid) begin
                eng_acc <= eng_acc + int'($signed(tx_data)) * 16 * (eng_cnt + 1);
                eng_cnt <= eng_cnt + 1;
            end else if (eng_cnt != 0) begin
                eng_rv  <= 1'b1;
                eng_rd  <= 8'(eng_acc >>> 4);
                eng_acc <= 0;
                eng_cnt <= 0;
            end
        end
    end

    assign res_valid = (eng_rv & eng_en) | spur;
    assign res_data  = spur ? spur_data : eng_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: got data %0h with nothing expected at %0t", out_data, $time);
            end else begin
                check("result", 64'(out_data), 64'(exp_q.pop_front()));
                check("ready_with_result", 64'(vec_ready), 64'd1);
            end
        end
    end

    task automatic send_vec(input logic [63:0] d, input logic [7:0] e, input bit push, input int abort_at);
        int b = 0;
        while (vec_ready !== 1'b1 && b < 200) begin
            @(posedge clk); #1; b++;
        end
        check("ready_before_send", 64'(vec_ready), 64'd1);
        vec_valid = 1'b1;
        vec_data  = d;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
        vec_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) return;
            check($sformatf("tx_valid_s%0d", k), 64'(tx_valid), 64'd1);
            check($sformatf("tx_data_s%0d", k), 64'(tx_data), 64'(d[k*8 +: 8]));
            if (k == 0) check("ready_low_in_send", 64'(vec_ready), 64'd0);
            if (k < N - 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check("tx_valid_after_burst", 64'(tx_valid), 64'd0);
        check("tx_data_hold_in_gap", 64'(tx_data), 64'(d[63:56]));
    endtask

    task automatic wait_result();
        int b = 0;
        while (out_valid !== 1'b1 && b < 100) begin
            @(posedge clk); #1; b++;
        end
        check("result_arrived", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("out_valid_one_cycle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int txc;
        bit seen;
        int ov0;

        tbl[0] = '{{8{8'h01}}, 8'h24};
        tbl[1] = '{{8{8'h02}}, 8'h48};
        tbl[2] = '{{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 8'hCC};
        tbl[3] = '{{8{8'hFF}}, 8'hDC};
        tbl[4] = '{{8'hFD, 8'h03, 8'hFD, 8'h03, 8'hFD, 8'h03, 8'hFD, 8'h03}, 8'hF4};
        tbl[5] = '{{8'h05, 56'h0}, 8'h28};

        rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0;
        eng_en = 1'b1; spur = 1'b0; spur_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_vec_ready", 64'(vec_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err_tmo", 64'(err_tmo), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        // Table of single vectors, each run to its result.
        for (int i = 0; i < 6; i++) begin
            send_vec(tbl[i].data, tbl[i].exp, 1'b1, N);
            wait_result();
        end

        // Back-to-back: vec_valid held high, second vector must wait for the first result.
        vec_valid = 1'b1;
        vec_data  = {8{8'h01}};
        @(posedge clk);
        exp_q.push_back(8'h24);
        #1;
        vec_data = {8{8'h02}};
        b = 0; txc = 0; seen = 1'b0;
        while (vec_ready !== 1'b1 && b < 200) begin
            if (tx_valid) txc++;
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1; b++;
        end
        if (out_valid) seen = 1'b1;
        check("b2b_ready_again", 64'(vec_ready), 64'd1);
        check("b2b_result_before_ready", 64'(seen), 64'd1);
        check("b2b_burst_len", 64'(txc), 64'd8);
        @(posedge clk);
        exp_q.push_back(8'h48);
        #1;
        vec_valid = 1'b0;
        check("b2b_second_tx", 64'(tx_valid), 64'd1);
        check("b2b_second_data", 64'(tx_data), 64'd2);
        wait_result();

        // Engine silent: timeout after exactly 64 WAIT cycles.
        eng_en = 1'b0;
        send_vec({8{8'h01}}, 8'h00, 1'b0, N);
        repeat (64) @(posedge clk);
        #1;
        check("tmo_not_yet", 64'(err_tmo), 64'd0);
        @(posedge clk); #1;
        check("tmo_set", 64'(err_tmo), 64'd1);
        check("tmo_idle_ready", 64'(vec_ready), 64'd1);
        check("tmo_no_out_valid", 64'(out_valid), 64'd0);
        eng_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("tmo_sticky", 64'(err_tmo), 64'd1);

        // Reset at burst sample 4.
        send_vec({8{8'h03}}, 8'h00, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_vec_ready", 64'(vec_ready), 64'd1);
        check("midrst_err_clear", 64'(err_tmo), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", 64'(vec_ready), 64'd1);
        send_vec({8{8'h01}}, 8'h24, 1'b1, N);
        wait_result();

        // Spurious res_valid in IDLE, then two pulses in WAIT.
        ov0 = ov_count;
        spur = 1'b1; spur_data = 8'h77;
        @(posedge clk); #1;
        spur = 1'b0;
        check("idle_spur_no_ov", 64'(out_valid), 64'd0);
        check("idle_spur_data_kept", 64'(out_data), 64'h24);
        eng_en = 1'b0;
        send_vec({8{8'h01}}, 8'h5A, 1'b1, N);
        @(posedge clk); #1;
        spur = 1'b1; spur_data = 8'h5A;
        @(posedge clk); #1;
        spur = 1'b0;
        check("wait_spur_ov", 64'(out_valid), 64'd1);
        check("wait_spur_data", 64'(out_data), 64'h5A);
        @(posedge clk); #1;
        spur = 1'b1; spur_data = 8'h33;
        @(posedge clk); #1;
        spur = 1'b0;
        check("second_spur_ignored", 64'(out_valid), 64'd0);
        check("second_spur_data_kept", 64'(out_data), 64'h5A);
        check("one_pulse_only", 64'(ov_count - ov0), 64'd1);
        eng_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
